// File: rtl/noc_flit_packetizer.sv
// rtl/noc_flit_packetizer.sv - wraps a command plus payload stream into head/body/tail flits for a mesh local port
module noc_flit_packetizer #(
    parameter int DATA_WIDTH  = 32,
    parameter int X_DIMENSION = 4,
    parameter int Y_DIMENSION = 4,
    parameter int MAX_LEN     = 8,
    localparam int X_DIM_W    = (X_DIMENSION > 1) ? $clog2(X_DIMENSION) : 1,
    localparam int Y_DIM_W    = (Y_DIMENSION > 1) ? $clog2(Y_DIMENSION) : 1,
    localparam int LEN_W      = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [X_DIM_W-1:0]    src_x_i,
    input  logic [Y_DIM_W-1:0]    src_y_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [X_DIM_W-1:0]    dest_x_i,
    input  logic [Y_DIM_W-1:0]    dest_y_i,
    input  logic [LEN_W-1:0]      len_i,
    input  logic [DATA_WIDTH-1:0] pl_data_i,
    input  logic                  pl_valid_i,
    output logic                  pl_ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  len_err_o,
    output logic [15:0]           pkt_cnt_o
);

    localparam int HEAD_W = 2 * X_DIM_W + 2 * Y_DIM_W + LEN_W;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    generate
        if (DATA_WIDTH < HEAD_W) begin : g_width_check
            $error("noc_flit_packetizer: DATA_WIDTH too narrow for the head flit fields");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, HEAD, BODY, TAIL} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      remaining;
    logic [15:0]           pkt_cnt_q;
    logic                  len_over;
    logic [LEN_W-1:0]      len_eff;
    logic [DATA_WIDTH-1:0] head_flit;
    logic                  cmd_fire;
    logic                  pl_fire;

    // Oversized requests are clamped rather than rejected so the mesh never sees an illegal length
    assign len_over  = (len_i > MAX_LEN_L);
    assign len_eff   = len_over ? MAX_LEN_L : len_i;
    assign head_flit = DATA_WIDTH'({len_eff, src_y_i, src_x_i, dest_y_i, dest_x_i});
    assign cmd_fire  = cmd_valid_i && cmd_ready_o;
    assign pl_fire   = pl_valid_i && pl_ready_o;
    assign pkt_cnt_o = pkt_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (cmd_fire) state_nxt = HEAD;
            HEAD: if (ready_i) state_nxt = (len_q == '0) ? IDLE : BODY;
            BODY: if (pl_fire && remaining == LEN_W'(1)) state_nxt = TAIL;
            TAIL: if (ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_o = 1'b0;
        pl_ready_o  = 1'b0;
        if (!rst_i) begin
            cmd_ready_o = (state == IDLE);
            pl_ready_o  = (state == BODY) && (!valid_o || ready_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o    <= '0;
            valid_o   <= 1'b0;
            len_err_o <= 1'b0;
            pkt_cnt_q <= '0;
            remaining <= '0;
            len_q     <= '0;
        end else begin
            len_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        data_o    <= head_flit;
                        valid_o   <= 1'b1;
                        len_q     <= len_eff;
                        len_err_o <= len_over;
                    end
                end
                HEAD: begin
                    if (ready_i) begin
                        valid_o   <= 1'b0;
                        remaining <= len_q;
                        if (len_q == '0) pkt_cnt_q <= pkt_cnt_q + 16'd1;
                    end
                end
                BODY: begin
                    // A drained slot with no new payload goes invalid instead of replaying old data
                    if (pl_fire) begin
                        data_o    <= pl_data_i;
                        valid_o   <= 1'b1;
                        remaining <= remaining - LEN_W'(1);
                    end else if (valid_o && ready_i) begin
                        valid_o <= 1'b0;
                    end
                end
                TAIL: begin
                    if (ready_i) begin
                        valid_o   <= 1'b0;
                        pkt_cnt_q <= pkt_cnt_q + 16'd1;
                    end
                end
                default: valid_o <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_flit_packetizer.sv
// tb/tb_noc_flit_packetizer.sv - table-driven and randomized checks of noc_flit_packetizer against a packet-level model
module tb_noc_flit_packetizer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  src_x_i, src_y_i;
    logic        cmd_valid_i, cmd_ready_o;
    logic [1:0]  dest_x_i, dest_y_i;
    logic [3:0]  len_i;
    logic [31:0] pl_data_i;
    logic        pl_valid_i, pl_ready_o;
    logic [31:0] data_o;
    logic        valid_o, ready_i, len_err_o;
    logic [15:0] pkt_cnt_o;

    int checks = 0;
    int fails  = 0;

    always #5 clk_i = ~clk_i;

    noc_flit_packetizer dut (
        .clk_i(clk_i), .rst_i(rst_i), .src_x_i(src_x_i), .src_y_i(src_y_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .dest_x_i(dest_x_i), .dest_y_i(dest_y_i), .len_i(len_i),
        .pl_data_i(pl_data_i), .pl_valid_i(pl_valid_i), .pl_ready_o(pl_ready_o),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .len_err_o(len_err_o), .pkt_cnt_o(pkt_cnt_o)
    );

    typedef struct {
        int          dx;
        int          dy;
        int          len;
        logic [31:0] exp_head;
        int          exp_err;
        int          ready_pct;
        int          pl_pct;
        int          stall_head;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Head flit from field positions: dest_x at bit 0, dest_y at 2, src_x at 4, src_y at 6, len at 8
    function automatic logic [31:0] ref_head(input int dx, input int dy, input int len);
        int l;
        l = (len > 8) ? 8 : len;
        return 32'(dx + dy * 4 + int'(src_x_i) * 16 + int'(src_y_i) * 64 + l * 256);
    endfunction

    task automatic run_packet(input vec_t v);
        logic [31:0] pl [8];
        logic [31:0] expq [$];
        logic [31:0] prev_data;
        logic [15:0] cnt_exp;
        int n, acc, seen, errs, cyc, stall_left;
        bit accepted, prev_stall;
        n = (v.len > 8) ? 8 : v.len;
        acc = 0; seen = 0; errs = 0; cyc = 0;
        stall_left = v.stall_head;
        accepted = 0; prev_stall = 0; prev_data = '0;
        for (int i = 0; i < 8; i++) pl[i] = $urandom;
        for (int i = 0; i < n; i++) expq.push_back(pl[i]);
        cnt_exp = pkt_cnt_o + 16'd1;
        dest_x_i = 2'(v.dx); dest_y_i = 2'(v.dy); len_i = 4'(v.len);
        cmd_valid_i = 1'b1;
        while (seen < n + 1 && cyc < 400) begin
            @(negedge clk_i);
            cyc++;
            if (accepted) cmd_valid_i = 1'b0;
            ready_i    = (accepted && stall_left > 0) ? 1'b0 : ($urandom_range(99) < v.ready_pct);
            pl_valid_i = ($urandom_range(99) < v.pl_pct);
            pl_data_i  = (acc < 8) ? pl[acc] : $urandom;
            #1;
            if (accepted && stall_left > 0) begin
                check("head_hold_data", data_o, v.exp_head);
                check("head_hold_valid", 32'(valid_o), 32'd1);
                check("head_hold_pl_ready", 32'(pl_ready_o), 32'd0);
                stall_left--;
            end
            if (prev_stall) begin
                check("stall_valid", 32'(valid_o), 32'd1);
                check("stall_data", data_o, prev_data);
            end
            if (len_err_o) errs++;
            if (valid_o && ready_i) begin
                if (seen == 0) check("head_flit", data_o, v.exp_head);
                else if (expq.size() > 0) check("payload_flit", data_o, expq.pop_front());
                else check("extra_flit", 32'(valid_o), 32'd0);
                seen++;
            end
            if (pl_valid_i && pl_ready_o) acc++;
            if (cmd_valid_i && cmd_ready_o) accepted = 1;
            prev_stall = valid_o && !ready_i;
            prev_data  = data_o;
        end
        if (seen < n + 1) check("packet_timeout", 32'(seen), 32'(n + 1));
        @(negedge clk_i);
        cmd_valid_i = 1'b0; ready_i = 1'b0; pl_valid_i = 1'b0;
        #1;
        check("end_valid", 32'(valid_o), 32'd0);
        check("end_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("end_pkt_cnt", 32'(pkt_cnt_o), 32'(cnt_exp));
        check("payloads_accepted", 32'(acc), 32'(n));
        check("len_err_pulses", 32'(errs), 32'(v.exp_err));
    endtask

    initial begin
        vec_t rv;
        int cyc, acc;
        src_x_i = 2'd0; src_y_i = 2'd2;
        rst_i = 1'b1; cmd_valid_i = 1'b0; dest_x_i = '0; dest_y_i = '0; len_i = '0;
        pl_data_i = '0; pl_valid_i = 1'b0; ready_i = 1'b0;

        //                 dx dy len  head        err rdy% pl%  stall
        vecs[0] = '{dx:3, dy:1, len:3,  exp_head:32'h387, exp_err:0, ready_pct:100, pl_pct:100, stall_head:0};
        vecs[1] = '{dx:3, dy:1, len:3,  exp_head:32'h387, exp_err:0, ready_pct:100, pl_pct:100, stall_head:2};
        vecs[2] = '{dx:0, dy:0, len:0,  exp_head:32'h080, exp_err:0, ready_pct:100, pl_pct:100, stall_head:0};
        vecs[3] = '{dx:2, dy:3, len:12, exp_head:32'h88E, exp_err:1, ready_pct:100, pl_pct:100, stall_head:0};
        vecs[4] = '{dx:1, dy:2, len:8,  exp_head:32'h889, exp_err:0, ready_pct:50,  pl_pct:60,  stall_head:1};
        vecs[5] = '{dx:3, dy:3, len:1,  exp_head:32'h18F, exp_err:0, ready_pct:40,  pl_pct:100, stall_head:0};
        vecs[6] = '{dx:0, dy:1, len:15, exp_head:32'h884, exp_err:1, ready_pct:70,  pl_pct:40,  stall_head:0};

        repeat (2) @(negedge clk_i);
        #1;
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_data", data_o, 32'd0);
        check("rst_len_err", 32'(len_err_o), 32'd0);
        check("rst_pkt_cnt", 32'(pkt_cnt_o), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
        check("rst_pl_ready", 32'(pl_ready_o), 32'd0);
        rst_i = 1'b0;
        #1;
        check("idle_cmd_ready", 32'(cmd_ready_o), 32'd1);

        for (int i = 0; i < 7; i++) run_packet(vecs[i]);

        for (int i = 0; i < 20; i++) begin
            rv.dx = $urandom_range(3); rv.dy = $urandom_range(3); rv.len = $urandom_range(12);
            rv.exp_head = ref_head(rv.dx, rv.dy, rv.len);
            rv.exp_err = (rv.len > 8) ? 1 : 0;
            rv.ready_pct = $urandom_range(100, 30); rv.pl_pct = $urandom_range(100, 30);
            rv.stall_head = $urandom_range(2);
            run_packet(rv);
        end

        // Reset after the second payload is accepted: packet is dropped and counter cleared
        @(negedge clk_i);
        dest_x_i = 2'd3; dest_y_i = 2'd1; len_i = 4'd3;
        cmd_valid_i = 1'b1; ready_i = 1'b1; pl_valid_i = 1'b1; pl_data_i = 32'hA5A5_0001;
        cyc = 0; acc = 0;
        while (acc < 2 && cyc < 50) begin
            @(negedge clk_i);
            cyc++;
            if (!cmd_ready_o) cmd_valid_i = 1'b0;
            #1;
            if (pl_valid_i && pl_ready_o) acc++;
        end
        check("mid_rst_reached", 32'(acc), 32'd2);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("mid_rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
        check("mid_rst_pl_ready", 32'(pl_ready_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("mid_rst_valid", 32'(valid_o), 32'd0);
        check("mid_rst_pkt_cnt", 32'(pkt_cnt_o), 32'd0);
        check("mid_rst_cmd_ready_after", 32'(cmd_ready_o), 32'd1);
        cmd_valid_i = 1'b0; pl_valid_i = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            #1;
            check("mid_rst_no_flits", 32'(valid_o), 32'd0);
        end

        // Counter wrap from 0xFFFF using a preloaded count
        @(negedge clk_i);
        force dut.pkt_cnt_q = 16'hFFFF;
        @(negedge clk_i);
        release dut.pkt_cnt_q;
        #1;
        check("preload_cnt", 32'(pkt_cnt_o), 32'hFFFF);
        rv = '{dx:0, dy:0, len:0, exp_head:32'h080, exp_err:0, ready_pct:100, pl_pct:100, stall_head:0};
        run_packet(rv);
        check("wrap_cnt", 32'(pkt_cnt_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
